// File: rtl/dp_resp_if.sv
// rtl/dp_resp_if.sv - command/feedback and sample/mean stream bundle for dp_resp
// Command and interrupt bit positions fall back to local defaults when def.v is not loaded.
`ifndef CMD_FLAG_W
`define CMD_FLAG_W 6
`define CMD_INIT 0
`define CMD_READ 1
`define CMD_AVG 2
`define CMD_COMP 3
`define CMD_SORT 4
`define CMD_OUT 5
`define INT_FLAG_W 6
`define INT_INIT 0
`define INT_READ 1
`define INT_AVG 2
`define INT_COMP 3
`define INT_SORT 4
`define INT_OUT 5
`endif

interface dp_resp_if #(
  parameter int DATA_W  = 8,
  parameter int NUM_GRP = 32
);
  logic [`CMD_FLAG_W-1:0]     cmd_flags;
  logic                       dp_cnt_rst;
  logic [`INT_FLAG_W-1:0]     fb_flags;
  logic                       in_valid;
  logic [DATA_W-1:0]          in_data;
  logic                       out_valid;
  logic [DATA_W-1:0]          out_data;
  logic [$clog2(NUM_GRP)-1:0] out_idx;

  modport master (
    output cmd_flags, dp_cnt_rst, in_valid, in_data,
    input  fb_flags, out_valid, out_data, out_idx
  );

  modport slave (
    input  cmd_flags, dp_cnt_rst, in_valid, in_data,
    output fb_flags, out_valid, out_data, out_idx
  );
endinterface

// File: rtl/dp_resp.sv
// rtl/dp_resp.sv - datapath responder: read, average, store, sort and stream group means
// Optional rounding mean selected by DP_AVG_ROUND_EN.
module dp_resp #(
  parameter int DATA_W   = 8,
  parameter int GRP_N    = 8,
  parameter int NUM_GRP  = 32,
  parameter int INIT_CYC = 4
) (
  input logic       clk,
  input logic       reset_n,
  dp_resp_if.slave  bus
);
  localparam int LG     = $clog2(GRP_N);
  localparam int ACC_W  = DATA_W + LG;
  localparam int IDX_W  = $clog2(NUM_GRP);
  localparam int CNT_W  = ((IDX_W > $clog2(INIT_CYC)) ? IDX_W : $clog2(INIT_CYC)) + 1;
  localparam int BEAT_W = LG + 1;
  localparam logic [`CMD_FLAG_W-1:0] READ_OH = `CMD_FLAG_W'(1) << `CMD_READ;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PULSE, S_HOLD} state_t;

  state_t                  state;
  logic [`CMD_FLAG_W-1:0]  phase;
  logic [ACC_W-1:0]        acc;
  logic [BEAT_W-1:0]       beat_cnt;
  logic [IDX_W-1:0]        grp_idx;
  logic [CNT_W-1:0]        cnt;
  logic [DATA_W-1:0]       mean;
  logic [DATA_W-1:0]       mean_calc;
  logic [DATA_W-1:0]       buffer [NUM_GRP];
  logic [DATA_W-1:0]       sorted [NUM_GRP];
  logic                    sort_par;
  logic                    cmd_onehot;
  logic                    accept;

  assign cmd_onehot = $onehot(bus.cmd_flags);
  assign accept     = bus.in_valid && (bus.cmd_flags == READ_OH) &&
                      (beat_cnt < BEAT_W'(GRP_N)) && !bus.dp_cnt_rst;
  // The first pass runs on the IDLE->RUN edge, so parity there is always even.
  assign sort_par   = (state == S_RUN) ? cnt[0] : 1'b0;

`ifdef DP_AVG_ROUND_EN
  logic [ACC_W:0]  rnd_sum;
  logic [DATA_W:0] rnd_q;
  logic            unused_rnd;
  assign rnd_sum    = {1'b0, acc} + (ACC_W+1)'(GRP_N / 2);
  assign rnd_q      = rnd_sum[ACC_W:LG];
  assign mean_calc  = rnd_q[DATA_W] ? {DATA_W{1'b1}} : rnd_q[DATA_W-1:0];
  assign unused_rnd = ^rnd_sum[LG-1:0];
`else
  logic unused_lsb;
  assign mean_calc  = acc[ACC_W-1:LG];
  assign unused_lsb = ^acc[LG-1:0];
`endif

  always_comb begin
    for (int i = 0; i < NUM_GRP; i++) sorted[i] = buffer[i];
    for (int i = 0; i + 1 < NUM_GRP; i++) begin
      if (((i % 2) == int'(sort_par)) && (buffer[i] > buffer[i+1])) begin
        sorted[i]   = buffer[i+1];
        sorted[i+1] = buffer[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      phase         <= '0;
      acc           <= '0;
      beat_cnt      <= '0;
      grp_idx       <= '0;
      cnt           <= '0;
      mean          <= '0;
      bus.fb_flags  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_idx   <= '0;
      for (int i = 0; i < NUM_GRP; i++) buffer[i] <= '0;
    end else begin
      bus.fb_flags  <= '0;
      bus.out_valid <= 1'b0;
      if (bus.dp_cnt_rst) beat_cnt <= '0;
      else if (accept)    beat_cnt <= beat_cnt + BEAT_W'(1);
      if (accept) acc <= acc + ACC_W'(bus.in_data);

      case (state)
        S_IDLE: begin
          if (cmd_onehot) begin
            phase <= bus.cmd_flags;
            state <= S_RUN;
            cnt   <= '0;
            if (bus.cmd_flags[`CMD_INIT]) begin
              acc     <= '0;
              grp_idx <= '0;
              for (int i = 0; i < NUM_GRP; i++) buffer[i] <= '0;
            end
            if (bus.cmd_flags[`CMD_SORT]) begin
              for (int i = 0; i < NUM_GRP; i++) buffer[i] <= sorted[i];
              cnt <= CNT_W'(1);
            end
          end
        end
        S_RUN: begin
          if ((bus.cmd_flags & phase) == '0) begin
            state <= S_IDLE;
          end else if (bus.cmd_flags == phase) begin
            if (phase[`CMD_INIT]) begin
              if (cnt == CNT_W'(INIT_CYC - 2)) begin
                bus.fb_flags[`INT_INIT] <= 1'b1;
                state <= S_PULSE;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
            if (phase[`CMD_READ]) begin
              if ((beat_cnt == BEAT_W'(GRP_N)) ||
                  (accept && (beat_cnt == BEAT_W'(GRP_N - 1)))) begin
                bus.fb_flags[`INT_READ] <= 1'b1;
                state <= S_PULSE;
              end
            end
            if (phase[`CMD_AVG]) begin
              mean <= mean_calc;
              bus.fb_flags[`INT_AVG] <= 1'b1;
              state <= S_PULSE;
            end
            if (phase[`CMD_COMP]) begin
              buffer[grp_idx] <= mean;
              beat_cnt        <= '0;
              grp_idx         <= (grp_idx == IDX_W'(NUM_GRP - 1)) ? '0 : grp_idx + IDX_W'(1);
              bus.fb_flags[`INT_COMP] <= 1'b1;
              state <= S_PULSE;
            end
            if (phase[`CMD_SORT]) begin
              if (cnt == CNT_W'(NUM_GRP)) begin
                bus.fb_flags[`INT_SORT] <= 1'b1;
                state <= S_PULSE;
              end else begin
                for (int i = 0; i < NUM_GRP; i++) buffer[i] <= sorted[i];
                cnt <= cnt + CNT_W'(1);
              end
            end
            if (phase[`CMD_OUT]) begin
              bus.out_valid <= 1'b1;
              bus.out_data  <= buffer[cnt[IDX_W-1:0]];
              bus.out_idx   <= cnt[IDX_W-1:0];
              cnt           <= cnt + CNT_W'(1);
              if (cnt == CNT_W'(NUM_GRP - 1)) begin
                bus.fb_flags[`INT_OUT] <= 1'b1;
                state <= S_PULSE;
              end
            end
          end
        end
        S_PULSE: begin
          if (phase[`CMD_AVG]) acc <= '0;
          state <= S_HOLD;
        end
        S_HOLD: begin
          if ((bus.cmd_flags & phase) == '0) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
